// File: rtl/rv32i_types.sv
// Shared types for the memory-side cache arbiter.
package rv32i_types;

    localparam int unsigned DEFAULT_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    // Encoding of the 1-bit last_grant register.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one shared memory port.
// One transaction at a time, round-robin on ties, never preempted.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = DEFAULT_LINE_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              imem_read,
    input  logic [ADDR_W-1:0] imem_address,
    output logic [LINE_W-1:0] imem_rdata,
    output logic              imem_resp,

    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_address,
    input  logic [LINE_W-1:0] dmem_wdata,
    output logic [LINE_W-1:0] dmem_rdata,
    output logic              dmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              write_q;
    logic              pmem_read_q;
    logic              pmem_write_q;

    logic i_req;
    logic d_req;
    logic grant_i;

    assign i_req = imem_read;
    assign d_req = dmem_read | dmem_write;
    // On a tie, favour whoever was not served last.
    assign grant_i = i_req & (~d_req | (last_grant_q == GRANT_D));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        state_q      <= SERVE_I;
                        addr_q       <= imem_address;
                        pmem_read_q  <= 1'b1;
                        pmem_write_q <= 1'b0;
                    end else if (d_req) begin
                        // A simultaneous read+write is performed as the write only.
                        state_q      <= SERVE_D;
                        addr_q       <= dmem_address;
                        wdata_q      <= dmem_wdata;
                        write_q      <= dmem_write;
                        pmem_read_q  <= ~dmem_write;
                        pmem_write_q <= dmem_write;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        state_q      <= IDLE;
                        last_grant_q <= GRANT_I;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state_q      <= IDLE;
                        last_grant_q <= GRANT_D;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign imem_resp  = (state_q == SERVE_I) & pmem_resp;
    assign dmem_resp  = (state_q == SERVE_D) & pmem_resp;
    assign imem_rdata = pmem_rdata;
    assign dmem_rdata = pmem_rdata;

    logic unused_write_q;
    assign unused_write_q = write_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter.
module tb_cache_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_read;
    logic [ADDR_W-1:0] imem_address;
    logic [LINE_W-1:0] imem_rdata;
    logic              imem_resp;
    logic              dmem_read;
    logic              dmem_write;
    logic [ADDR_W-1:0] dmem_address;
    logic [LINE_W-1:0] dmem_wdata;
    logic [LINE_W-1:0] dmem_rdata;
    logic              dmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int checks = 0;
    int errors = 0;

    logic [LINE_W-1:0] pat_a;
    logic [LINE_W-1:0] pat_b;
    logic [LINE_W-1:0] pat_c;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_address (dmem_address),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0; pmem_resp = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL rst_pmem_read: got %b expected 0", pmem_read); end
        checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL rst_pmem_write: got %b expected 0", pmem_write); end
        checks++; if (pmem_address !== 32'h0) begin errors++; $display("FAIL rst_address: got %0h expected 0", pmem_address); end
        checks++; if (pmem_wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %0h expected 0", pmem_wdata); end
        checks++; if ({imem_resp, dmem_resp} !== 2'b00) begin errors++; $display("FAIL rst_resp: got %b expected 00", {imem_resp, dmem_resp}); end
    endtask

    task automatic test_idle_resp();
        pmem_resp = 1'b1;
        #1;
        checks++; if ({imem_resp, dmem_resp} !== 2'b00) begin errors++; $display("FAIL idle_resp_fwd: got %b expected 00", {imem_resp, dmem_resp}); end
        tick();
        pmem_resp = 1'b0;
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL idle_resp_state: got %b expected 00", {pmem_read, pmem_write}); end
    endtask

    task automatic test_i_read();
        imem_read = 1'b1; imem_address = 32'h0000_0060;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin errors++; $display("FAIL i_strobe_c%0d: got r=%b w=%b expected r=1 w=0", c, pmem_read, pmem_write); end
            checks++; if (pmem_address !== 32'h60) begin errors++; $display("FAIL i_address_c%0d: got %0h expected 60", c, pmem_address); end
            if (c == 2) begin
                pmem_resp = 1'b1; pmem_rdata = pat_a; imem_read = 1'b0;
                #1;
                checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL i_resp: got %b expected 1", imem_resp); end
                checks++; if (imem_rdata !== pat_a) begin errors++; $display("FAIL i_rdata: got %0h expected %0h", imem_rdata, pat_a); end
                checks++; if (dmem_rdata !== pat_a) begin errors++; $display("FAIL d_rdata_passthru: got %0h expected %0h", dmem_rdata, pat_a); end
            end else begin
                checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL i_resp_early_c%0d: got %b expected 0", c, imem_resp); end
            end
            checks++; if (dmem_resp !== 1'b0) begin errors++; $display("FAIL i_dresp_c%0d: got %b expected 0", c, dmem_resp); end
            tick();
        end
        pmem_resp = 1'b0;
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL i_read_done: got %b expected 0", pmem_read); end
        #1;
        checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL i_resp_after: got %b expected 0", imem_resp); end
    endtask

    task automatic test_d_write();
        dmem_write = 1'b1; dmem_address = 32'h0000_1000; dmem_wdata = pat_b;
        tick();
        checks++; if ({pmem_read, pmem_write} !== 2'b01) begin errors++; $display("FAIL d_wr_strobe: got r,w=%b expected 01", {pmem_read, pmem_write}); end
        checks++; if (pmem_wdata !== pat_b) begin errors++; $display("FAIL d_wr_wdata: got %0h expected %0h", pmem_wdata, pat_b); end
        checks++; if (pmem_address !== 32'h1000) begin errors++; $display("FAIL d_wr_address: got %0h expected 1000", pmem_address); end
        dmem_wdata = pat_c;
        tick();
        checks++; if (pmem_wdata !== pat_b) begin errors++; $display("FAIL d_wr_wdata_held: got %0h expected %0h", pmem_wdata, pat_b); end
        pmem_resp = 1'b1; dmem_write = 1'b0;
        #1;
        checks++; if ({imem_resp, dmem_resp} !== 2'b01) begin errors++; $display("FAIL d_wr_resp: got i,d=%b expected 01", {imem_resp, dmem_resp}); end
        tick();
        pmem_resp = 1'b0;
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL d_wr_done: got %b expected 00", {pmem_read, pmem_write}); end
    endtask

    task automatic test_tie();
        do_reset();
        imem_read = 1'b1; imem_address = 32'h100;
        dmem_read = 1'b1; dmem_address = 32'h200;
        tick();
        checks++; if (pmem_address !== 32'h200 || pmem_read !== 1'b1) begin errors++; $display("FAIL tie1_grant: got addr=%0h r=%b expected addr=200 r=1", pmem_address, pmem_read); end
        pmem_resp = 1'b1; dmem_read = 1'b0;
        #1;
        checks++; if ({imem_resp, dmem_resp} !== 2'b01) begin errors++; $display("FAIL tie1_resp: got i,d=%b expected 01", {imem_resp, dmem_resp}); end
        tick();
        pmem_resp = 1'b0;
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL tie_gap: got %b expected 00", {pmem_read, pmem_write}); end
        tick();
        checks++; if (pmem_address !== 32'h100 || pmem_read !== 1'b1) begin errors++; $display("FAIL tie2_grant: got addr=%0h r=%b expected addr=100 r=1", pmem_address, pmem_read); end
        pmem_resp = 1'b1; dmem_read = 1'b1;
        #1;
        checks++; if ({imem_resp, dmem_resp} !== 2'b10) begin errors++; $display("FAIL tie2_resp: got i,d=%b expected 10", {imem_resp, dmem_resp}); end
        tick();
        pmem_resp = 1'b0;
        tick();
        checks++; if (pmem_address !== 32'h200) begin errors++; $display("FAIL tie3_grant: got addr=%0h expected 200", pmem_address); end
        pmem_resp = 1'b1; imem_read = 1'b0; dmem_read = 1'b0;
        tick();
        pmem_resp = 1'b0;
    endtask

    task automatic test_addr_change();
        imem_read = 1'b1; imem_address = 32'h340;
        tick();
        imem_address = 32'h000D_EAD0;
        tick();
        checks++; if (pmem_address !== 32'h340) begin errors++; $display("FAIL addr_hold: got %0h expected 340", pmem_address); end
        pmem_resp = 1'b1; imem_read = 1'b0;
        tick();
        pmem_resp = 1'b0;
    endtask

    task automatic test_reset_mid();
        dmem_read = 1'b1; dmem_address = 32'h400;
        tick();
        checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL mid_started: got %b expected 1", pmem_read); end
        reset = 1'b1; dmem_read = 1'b0;
        tick();
        reset = 1'b0;
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL mid_strobes: got %b expected 00", {pmem_read, pmem_write}); end
        checks++; if (pmem_address !== 32'h0) begin errors++; $display("FAIL mid_addr_clr: got %0h expected 0", pmem_address); end
        pmem_resp = 1'b1;
        #1;
        checks++; if ({imem_resp, dmem_resp} !== 2'b00) begin errors++; $display("FAIL mid_late_resp: got i,d=%b expected 00", {imem_resp, dmem_resp}); end
        tick();
        pmem_resp = 1'b0;
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL mid_after: got %b expected 00", {pmem_read, pmem_write}); end
    endtask

    task automatic test_rw_both();
        dmem_read = 1'b1; dmem_write = 1'b1; dmem_address = 32'h200; dmem_wdata = pat_c;
        tick();
        checks++; if ({pmem_read, pmem_write} !== 2'b01) begin errors++; $display("FAIL rw_strobe: got r,w=%b expected 01", {pmem_read, pmem_write}); end
        checks++; if (pmem_wdata !== pat_c) begin errors++; $display("FAIL rw_wdata: got %0h expected %0h", pmem_wdata, pat_c); end
        pmem_resp = 1'b1; dmem_read = 1'b0; dmem_write = 1'b0;
        #1;
        checks++; if (dmem_resp !== 1'b1) begin errors++; $display("FAIL rw_resp: got %b expected 1", dmem_resp); end
        tick();
        pmem_resp = 1'b0;
    endtask

    initial begin
        pat_a = {8{32'hA5A5_0001}};
        pat_b = {8{32'h1234_5678}};
        pat_c = {8{32'hC0DE_F00D}};
        reset = 1'b1;
        imem_read = 1'b0; imem_address = '0;
        dmem_read = 1'b0; dmem_write = 1'b0; dmem_address = '0; dmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        test_reset();
        test_idle_resp();
        test_i_read();
        test_d_write();
        test_tie();
        test_addr_change();
        test_reset_mid();
        test_rw_both();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, physical address width.
REQ-002 Parameter: LINE_W, default 256, cache line width in bits.
REQ-003 Ports, clock and reset first:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_read  input  1  I-cache line-fill request.
- imem_address  input  ADDR_W  I-cache line address.
- imem_rdata  output  LINE_W  fill data to I-cache.
- imem_resp  output  1  I-cache transaction complete.
- dmem_read  input  1  D-cache line-fill request.
- dmem_write  input  1  D-cache writeback request.
- dmem_address  input  ADDR_W  D-cache line address.
- dmem_wdata  input  LINE_W  D-cache writeback data.
- dmem_rdata  output  LINE_W  fill data to D-cache.
- dmem_resp  output  1  D-cache transaction complete.
- pmem_read  output  1  shared memory read strobe.
- pmem_write  output  1  shared memory write strobe.
- pmem_address  output  ADDR_W  shared memory address.
- pmem_wdata  output  LINE_W  shared memory write data.
- pmem_rdata  input  LINE_W  shared memory read data.
- pmem_resp  input  1  shared memory done, one-cycle pulse.

Function
REQ-004 FSM states: IDLE, SERVE_I, SERVE_D; exactly one active.
REQ-005 In IDLE, an I request is imem_read; a D request is dmem_read or dmem_write.
REQ-006 IDLE with only I request: next state SERVE_I. Only D request: next state SERVE_D. Neither: stay IDLE.
REQ-007 IDLE with both requests: grant the requester not granted last, tracked by a 1-bit last_grant register.
REQ-008 Capture imem_address, or dmem_address, dmem_wdata and dmem_write, into registers on the IDLE->SERVE_x edge. Drive pmem_address, pmem_wdata and the op from those registers for the whole transaction.
REQ-009 In SERVE_I, pmem_read=1 and pmem_write=0.
REQ-010 In SERVE_D, pmem_write equals the latched dmem_write and pmem_read equals its inverse.
REQ-011 In IDLE, pmem_read=0 and pmem_write=0.
REQ-012 If dmem_read and dmem_write are both asserted, treat it as a write; the read is not performed.
REQ-013 pmem_read/pmem_write first assert the cycle after the request is sampled in IDLE (1-cycle grant latency).
REQ-014 In SERVE_I with pmem_resp=1, imem_resp=1 combinationally in the same cycle; otherwise imem_resp=0.
REQ-015 In SERVE_D with pmem_resp=1, dmem_resp=1 combinationally in the same cycle; otherwise dmem_resp=0.
REQ-016 The non-granted resp is always 0.
REQ-017 imem_rdata and dmem_rdata both equal pmem_rdata at all times; they are valid only with the matching resp.
REQ-018 On pmem_resp, next state is IDLE and last_grant is updated to the served requester.
REQ-019 Back-to-back transactions have at least one IDLE cycle between them.
REQ-020 The granted transaction is never preempted. Requests arriving during SERVE_x are held by the requester and sampled on return to IDLE.
REQ-021 pmem_resp while in IDLE is ignored: no state change, no resp forwarded.

Reset
REQ-022 On reset=1 at a clock edge:
- state=IDLE.
- last_grant=I, so the first tie grants D.
- Address/data registers cleared to 0.
- pmem_read=0, pmem_write=0, imem_resp=0, dmem_resp=0 from the following cycle.
REQ-023 Reset mid-transaction abandons it: no resp is issued, and a pmem_resp arriving after reset is ignored per REQ-021.

Structure
REQ-024 Put the enum arb_state_t {IDLE, SERVE_I, SERVE_D} and the constant LINE_W default in package rv32i_types.
REQ-025 Single module with no sub-modules. Output muxing of address/wdata is inline from the latched registers.

Verification
REQ-026 I-only read: imem_read=1, imem_address=0x00000060; pmem_resp after 3 cycles with rdata=pattern A.
- Expected: pmem_read high 3 cycles, pmem_address=0x60, imem_resp one cycle with imem_rdata=A, dmem_resp=0 throughout.
REQ-027 D writeback: dmem_write=1, address 0x00001000, wdata=pattern B.
- Expected: pmem_write=1, pmem_read=0, pmem_wdata=B, dmem_resp on pmem_resp.
REQ-028 Tie after reset: imem_read and dmem_read both asserted.
- Expected: D served first, I served second with one IDLE cycle between; then both again gives D again (last_grant=I).
REQ-029 Address change mid-transaction: imem_address changes during SERVE_I.
- Expected: pmem_address keeps the latched value.
REQ-030 Reset asserted during SERVE_D, then pmem_resp pulses.
- Expected: next cycle IDLE with strobes 0, and no dmem_resp.
REQ-031 Simultaneous dmem_read and dmem_write at address 0x200.
- Expected: pmem_write=1, pmem_read=0.
